// File: rtl/gpio_ahbl_cmd_arbiter.sv
// gpio_ahbl_cmd_arbiter: shares one AHB-Lite master port between two
// req/ack command sources. Round-robin grant, single transfers only.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | sample REQ0/REQ1, grant, latch command, alignment check
// ADDR   | NONSEQ address phase, held while HREADY=0
// DATA   | data phase (HTRANS=IDLE), wait for HREADY, capture response
// RESP   | one-cycle ACK to the granted requester, REQ ignored
module gpio_ahbl_cmd_arbiter (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic        WR0,
  input  logic        WR1,
  input  logic [31:0] ADDR0,
  input  logic [31:0] ADDR1,
  input  logic [2:0]  SIZE0,
  input  logic [2:0]  SIZE1,
  input  logic [31:0] WDATA0,
  input  logic [31:0] WDATA1,
  output logic        ACK0,
  output logic        ACK1,
  output logic [31:0] RDATA,
  output logic        ERR,
  output logic        BUSY,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        gnt_q, gnt_d;
  logic        wr_q, wr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] haddr_q, haddr_d;
  logic [1:0]  htrans_q, htrans_d;
  logic        hwrite_q, hwrite_d;
  logic [2:0]  hsize_q, hsize_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        busy_q, busy_d;

  logic        sel;
  logic        sel_wr;
  logic [31:0] sel_addr;
  logic [2:0]  sel_size;
  logic [31:0] sel_wdata;
  logic        sel_bad;

  // Round-robin pick between the requesters and alignment check of the winner.
  always_comb begin
    sel = 1'b0;
    if (REQ0 && REQ1) sel = ~last_q;
    else if (REQ1)    sel = 1'b1;
    sel_wr    = sel ? WR1    : WR0;
    sel_addr  = sel ? ADDR1  : ADDR0;
    sel_size  = sel ? SIZE1  : SIZE0;
    sel_wdata = sel ? WDATA1 : WDATA0;
    sel_bad   = (sel_size > 3'b010) ||
                ((sel_size == 3'b001) && sel_addr[0]) ||
                ((sel_size == 3'b010) && (sel_addr[1:0] != 2'b00));
  end

  // Next-state and registered-output computation for the command sequencer.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    haddr_d  = haddr_q;
    htrans_d = htrans_q;
    hwrite_d = hwrite_q;
    hsize_d  = hsize_q;
    hwdata_d = hwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (REQ0 || REQ1) begin
          gnt_d    = sel;
          last_d   = sel;
          wr_d     = sel_wr;
          wdata_d  = sel_wdata;
          haddr_d  = sel_addr;
          hwrite_d = sel_wr;
          hsize_d  = sel_size;
          if (sel_bad) begin
            // Rejected locally: complete with error, bus stays idle.
            state_d = S_RESP;
            err_d   = 1'b1;
            ack0_d  = ~sel;
            ack1_d  = sel;
          end else begin
            state_d  = S_ADDR;
            htrans_d = TR_NONSEQ;
          end
        end
      end
      S_ADDR: begin
        if (HREADY) begin
          state_d  = S_DATA;
          htrans_d = TR_IDLE;
          if (wr_q) hwdata_d = wdata_q;
        end
      end
      S_DATA: begin
        if (HREADY) begin
          state_d = S_RESP;
          if (!wr_q) rdata_d = HRDATA;
          err_d  = HRESP;
          ack0_d = ~gnt_q;
          ack1_d = gnt_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      wr_q     <= 1'b0;
      wdata_q  <= 32'h0;
      haddr_q  <= 32'h0;
      htrans_q <= TR_IDLE;
      hwrite_q <= 1'b0;
      hsize_q  <= 3'b000;
      hwdata_q <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      haddr_q  <= haddr_d;
      htrans_q <= htrans_d;
      hwrite_q <= hwrite_d;
      hsize_q  <= hsize_d;
      hwdata_q <= hwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      busy_q   <= busy_d;
    end
  end

  assign ACK0      = ack0_q;
  assign ACK1      = ack1_q;
  assign RDATA     = rdata_q;
  assign ERR       = err_q;
  assign BUSY      = busy_q;
  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HWDATA    = hwdata_q;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_gpio_ahbl_cmd_arbiter.sv
// Bench for gpio_ahbl_cmd_arbiter: directed commands, a transaction-walking
// reference model, a per-cycle compare process and literal timing checks.
module tb_gpio_ahbl_cmd_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        REQ0, REQ1, WR0, WR1;
  logic [31:0] ADDR0, ADDR1, WDATA0, WDATA1;
  logic [2:0]  SIZE0, SIZE1;
  logic        ACK0, ACK1, ERR, BUSY, HWRITE, HMASTLOCK;
  logic [31:0] RDATA, HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        HREADY, HRESP;

  gpio_ahbl_cmd_arbiter dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .REQ0(REQ0), .REQ1(REQ1), .WR0(WR0), .WR1(WR1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .SIZE0(SIZE0), .SIZE1(SIZE1),
    .WDATA0(WDATA0), .WDATA1(WDATA1),
    .ACK0(ACK0), .ACK1(ACK1), .RDATA(RDATA), .ERR(ERR), .BUSY(BUSY),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int n_ack0  = 0;
  int n_ack1  = 0;

  always @(posedge HCLK) cyc++;
  always @(negedge HCLK) begin
    if (ACK0) n_ack0++;
    if (ACK1) n_ack1++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        exp_ack0, exp_ack1, exp_busy, exp_err, exp_hwrite;
  logic [1:0]  exp_htrans;
  logic [2:0]  exp_hsize;
  logic [31:0] exp_rdata, exp_haddr, exp_hwdata;
  bit          chk_bus, chk_wdata;
  bit          m_last, m_ab, m_done, m_bad;
  int          m_w;
  logic        m_wr;
  logic [31:0] m_addr, m_wdata;
  logic [2:0]  m_size;

  task automatic mdl_reset();
    exp_ack0 = 0; exp_ack1 = 0; exp_busy = 0; exp_err = 0; exp_htrans = 2'b00;
    exp_rdata = 0; exp_haddr = 0; exp_hwrite = 0; exp_hsize = 0; exp_hwdata = 0;
    chk_bus = 1; chk_wdata = 1; m_last = 1;
  endtask

  task automatic mdl_tick(output bit ab);
    @(posedge HCLK);
    ab = HRESET;
    if (ab) mdl_reset();
  endtask

  task automatic mdl_ack(input int w);
    if (w == 0) exp_ack0 = 1; else exp_ack1 = 1;
  endtask

  // Walks one command at a time through the spec's phases; each loop head
  // is the clock edge that closes an idle cycle, where requests are sampled.
  initial begin : model
    mdl_reset();
    forever begin
      @(posedge HCLK);
      if (HRESET) begin mdl_reset(); continue; end
      if (!(REQ0 || REQ1)) continue;
      m_w     = (REQ0 && REQ1) ? (m_last ? 0 : 1) : (REQ1 ? 1 : 0);
      m_last  = (m_w == 1);
      m_wr    = m_w ? WR1 : WR0;
      m_addr  = m_w ? ADDR1 : ADDR0;
      m_size  = m_w ? SIZE1 : SIZE0;
      m_wdata = m_w ? WDATA1 : WDATA0;
      m_bad   = (m_size > 2) || (m_size == 1 && m_addr[0]) ||
                (m_size == 2 && m_addr[1:0] != 2'b00);
      exp_busy = 1; chk_bus = 0; chk_wdata = 0; m_ab = 0;
      if (m_bad) begin
        exp_err = 1;
        mdl_ack(m_w);
      end else begin
        exp_htrans = 2'b10; exp_haddr = m_addr; exp_hwrite = m_wr; exp_hsize = m_size;
        chk_bus = 1;
        m_done = 0;
        while (!m_ab && !m_done) begin mdl_tick(m_ab); if (!m_ab && HREADY) m_done = 1; end
        if (!m_ab) begin
          exp_htrans = 2'b00;
          if (m_wr) begin exp_hwdata = m_wdata; chk_wdata = 1; end
          m_done = 0;
          while (!m_ab && !m_done) begin mdl_tick(m_ab); if (!m_ab && HREADY) m_done = 1; end
          if (!m_ab) begin
            if (!m_wr) exp_rdata = HRDATA;
            exp_err = HRESP;
            mdl_ack(m_w);
          end
        end
      end
      if (!m_ab) begin
        mdl_tick(m_ab);
        if (!m_ab) begin
          exp_ack0 = 0; exp_ack1 = 0; exp_busy = 0; chk_bus = 0; chk_wdata = 0;
        end
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge HCLK) begin
    if (!HRESET) begin
      chk("ack0", {31'b0, ACK0}, {31'b0, exp_ack0});
      chk("ack1", {31'b0, ACK1}, {31'b0, exp_ack1});
      chk("busy", {31'b0, BUSY}, {31'b0, exp_busy});
      chk("htrans", {30'b0, HTRANS}, {30'b0, exp_htrans});
      chk("err", {31'b0, ERR}, {31'b0, exp_err});
      chk("rdata", RDATA, exp_rdata);
      chk("hburst", {29'b0, HBURST}, 32'h0);
      chk("hprot", {28'b0, HPROT}, 32'h3);
      chk("hmastlock", {31'b0, HMASTLOCK}, 32'h0);
      if (chk_bus) begin
        chk("haddr", HADDR, exp_haddr);
        chk("hwrite", {31'b0, HWRITE}, {31'b0, exp_hwrite});
        chk("hsize", {29'b0, HSIZE}, {29'b0, exp_hsize});
      end
      if (chk_wdata) chk("hwdata", HWDATA, exp_hwdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic edge2();
    @(posedge HCLK); #2;
  endtask

  task automatic issue(input int r, input logic wr, input logic [31:0] a,
                       input logic [2:0] sz, input logic [31:0] wd);
    if (r == 0) begin WR0 = wr; ADDR0 = a; SIZE0 = sz; WDATA0 = wd; REQ0 = 1; end
    else        begin WR1 = wr; ADDR1 = a; SIZE1 = sz; WDATA1 = wd; REQ1 = 1; end
  endtask

  task automatic wait_ack(input int r, input int budget, output int at);
    bit seen;
    seen = 0;
    at = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge HCLK);
      if ((r == 0 && ACK0) || (r == 1 && ACK1)) begin seen = 1; at = cyc; end
    end
    vectors++;
    if (!seen) begin
      errors++;
      $display("FAIL ack%0d_timeout: got none expected ACK within %0d cycles", r, budget);
    end
  endtask

  task automatic drop(input int r);
    edge2();
    if (r == 0) REQ0 = 0; else REQ1 = 0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "timeout");
  end

  int rc, a0, a1, n0;
  logic [31:0] mis_addr [3] = '{32'h82, 32'h81, 32'h80};
  logic [2:0]  mis_size [3] = '{3'b010, 3'b001, 3'b011};

  initial begin : stim
    HRESET = 1; REQ0 = 0; REQ1 = 0; WR0 = 0; WR1 = 0;
    ADDR0 = 0; ADDR1 = 0; SIZE0 = 0; SIZE1 = 0; WDATA0 = 0; WDATA1 = 0;
    HRDATA = 32'h1111_0000; HREADY = 1; HRESP = 0;
    repeat (3) edge2();
    @(negedge HCLK);
    chk("rst_htrans", {30'b0, HTRANS}, 32'h0);
    chk("rst_busy", {31'b0, BUSY}, 32'h0);
    chk("rst_rdata", RDATA, 32'h0);
    chk("rst_haddr", HADDR, 32'h0);

    // Simultaneous requests straight out of reset: requester 0 first.
    edge2();
    HRESET = 0;
    issue(0, 0, 32'h0000_0010, 3'b010, 32'h0);
    issue(1, 1, 32'h0000_0044, 3'b010, 32'hDEAD_BEEF);
    rc = cyc;
    wait_ack(0, 10, a0);
    chk("tie_ack0_lat", a0 - rc, 3);
    chk("tie_rdata", RDATA, 32'h1111_0000);
    drop(0);
    wait_ack(1, 10, a1);
    chk("tie_ack1_gap", a1 - a0, 4);
    drop(1);
    edge2();

    // Read, no wait states.
    HRDATA = 32'hA5A5_0001;
    issue(0, 0, 32'h80, 3'b010, 32'h0);
    rc = cyc;
    @(negedge HCLK);
    @(negedge HCLK);
    chk("rd_nonseq_n1", {30'b0, HTRANS}, 32'h2);
    wait_ack(0, 10, a0);
    chk("rd_ack_lat", a0 - rc, 3);
    chk("rd_rdata", RDATA, 32'hA5A5_0001);
    chk("rd_err", {31'b0, ERR}, 32'h0);
    drop(0);
    edge2();

    // Write with two wait states in the data phase.
    issue(1, 1, 32'h40, 3'b010, 32'h0000_00FF);
    rc = cyc;
    repeat (2) edge2();
    HREADY = 0;
    @(negedge HCLK);
    chk("wr_hwdata_wait", HWDATA, 32'hFF);
    repeat (2) edge2();
    HREADY = 1;
    wait_ack(1, 10, a1);
    chk("wr_ack_lat", a1 - rc, 5);
    chk("wr_rdata_kept", RDATA, 32'hA5A5_0001);
    drop(1);
    edge2();

    // Slave error: one wait cycle with HRESP, then error completion.
    issue(0, 0, 32'h84, 3'b010, 32'h0);
    rc = cyc;
    repeat (2) edge2();
    HRESP = 1; HREADY = 0;
    edge2();
    HREADY = 1;
    wait_ack(0, 10, a0);
    chk("err_ack_lat", a0 - rc, 4);
    chk("err_flag", {31'b0, ERR}, 32'h1);
    drop(0);
    HRESP = 0;
    edge2();

    // Misaligned / illegal commands: ACK at N+1, no bus activity.
    for (int i = 0; i < 3; i++) begin
      issue(0, 0, mis_addr[i], mis_size[i], 32'h0);
      rc = cyc;
      wait_ack(0, 6, a0);
      chk("mis_ack_lat", a0 - rc, 1);
      chk("mis_err", {31'b0, ERR}, 32'h1);
      chk("mis_htrans", {30'b0, HTRANS}, 32'h0);
      drop(0);
      edge2();
    end

    // Tie after requester 0 was last: requester 1 wins.
    HRDATA = 32'h0BAD_F00D;
    issue(0, 0, 32'h8, 3'b001, 32'h0);
    issue(1, 1, 32'hC, 3'b000, 32'h0000_00AA);
    rc = cyc;
    wait_ack(1, 10, a1);
    chk("rr_ack1_lat", a1 - rc, 3);
    drop(1);
    wait_ack(0, 10, a0);
    chk("rr_ack0_gap", a0 - a1, 4);
    chk("rr_rdata", RDATA, 32'h0BAD_F00D);
    drop(0);
    edge2();

    // Reset during the data phase of a write.
    issue(0, 1, 32'h10, 3'b010, 32'h5555_AAAA);
    n0 = n_ack0;
    repeat (2) edge2();
    HREADY = 0;
    edge2();
    HRESET = 1; REQ0 = 0; HREADY = 1;
    @(negedge HCLK);
    chk("rstdata_htrans", {30'b0, HTRANS}, 32'h0);
    chk("rstdata_busy", {31'b0, BUSY}, 32'h0);
    edge2();
    edge2();
    HRESET = 0;
    repeat (2) edge2();
    chk("rstdata_no_ack", n_ack0 - n0, 0);
    HRDATA = 32'h1234_5678;
    issue(0, 0, 32'h20, 3'b010, 32'h0);
    rc = cyc;
    wait_ack(0, 10, a0);
    chk("post_rst_lat", a0 - rc, 3);
    chk("post_rst_rdata", RDATA, 32'h1234_5678);
    drop(0);
    repeat (3) edge2();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/gpio_ahbl_cmd_arbiter.md
# gpio_ahbl_cmd_arbiter

Two-requester AHB-Lite master arbiter that shares one AHB-Lite master port between two command sources. Typical sources are a test sequencer and a GPIO configuration engine, and the shared port drives the CoreGPIO slave. Each requester issues single read/write commands over a req/ack handshake. The block serialises them with round-robin priority, runs the AHB-Lite address and data phases (with wait states and error response), and returns read data and status.

## Interface
Parameters: none. Address and data widths are fixed at 32 bits.

Ports (clock and reset first):
- HCLK  in  1  system/bus clock; all logic on rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- REQ0 / REQ1  in  1  command request, requester 0 / 1.
- WR0 / WR1  in  1  1 = write, 0 = read.
- ADDR0 / ADDR1  in  32  byte address.
- SIZE0 / SIZE1  in  3  HSIZE encoding; only 000, 001, 010 are legal.
- WDATA0 / WDATA1  in  32  write data, already lane-placed by the requester.
- ACK0 / ACK1  out  1  one-cycle completion pulse.
- RDATA  out  32  read data captured on completion; shared by both requesters.
- ERR  out  1  completion status, valid while an ACK is high.
- BUSY  out  1  high in every state except IDLE.
- HADDR  out  32, HTRANS  out  2, HWRITE  out  1, HSIZE  out  3, HWDATA  out  32: AHB-Lite master outputs.
- HBURST  out  3, HPROT  out  4, HMASTLOCK  out  1: constants 000, 0011 and 0.
- HRDATA  in  32, HREADY  in  1, HRESP  in  1: AHB-Lite slave response.

## Operation
- State machine: IDLE, ADDR, DATA, RESP.
- **IDLE**
  - Samples REQ0/REQ1.
  - If exactly one is high, grant it.
  - If both are high, grant the requester that is not LAST. LAST is the last-granted index and resets to 1, so requester 0 wins the first tie.
  - On grant: latch the requester's WR, ADDR, SIZE and WDATA into registers; update LAST.
  - Alignment check on the latched command:
    - SIZE=001 with ADDR[0]=1 is misaligned.
    - SIZE=010 with ADDR[1:0]≠00 is misaligned.
    - SIZE above 010 is illegal.
  - Misaligned or illegal command: go to RESP with ERR=1 and no bus activity.
  - Otherwise go to ADDR.
- **ADDR**
  - Drive HTRANS=10 (NONSEQ) with HADDR, HWRITE and HSIZE from the latched command.
  - If HREADY=1, go to DATA.
  - If HREADY=0, hold ADDR with outputs unchanged.
- **DATA**
  - Drive HTRANS=00 (IDLE). HADDR, HWRITE and HSIZE keep their values.
  - On a write, drive HWDATA = latched WDATA.
  - When HREADY=1:
    - Capture HRDATA into RDATA on reads; RDATA is unchanged on writes.
    - Capture HRESP into ERR.
    - Go to RESP.
  - HRESP=1 with HREADY=0 (first error cycle): keep waiting.
- **RESP**
  - Pulse ACK of the granted requester for exactly one cycle.
  - REQ is not sampled in this state.
  - Go to IDLE.
- Requester rules:
  - Hold REQ and its command fields stable from assertion until ACK.
  - Drop REQ on the edge that ends the ACK cycle.
  - A REQ still high in the following IDLE cycle is treated as a new command.
- Bus discipline: single transfers only. There is no back-to-back pipelining; at least one IDLE cycle separates commands.
- RDATA and ERR hold their values until the next completion.

## Timing
- Reset values (applied asynchronously while HRESET=1):
  - State IDLE, LAST=1.
  - HTRANS=00, HADDR=0, HWRITE=0, HSIZE=000, HWDATA=0.
  - RDATA=0, ERR=0, ACK0=ACK1=0, BUSY=0.
- All outputs are registered.
- Minimum latency, with REQ first sampled high in cycle N and no wait states:
  - N+1: ADDR state, HTRANS=NONSEQ.
  - N+2: DATA state.
  - N+3: ACK high.
- Each HREADY=0 cycle in ADDR or DATA adds one cycle of latency.
- A misaligned command raises ACK with ERR=1 in cycle N+1.
- Best-case throughput: one command per 4 cycles.
- Reset mid-operation:
  - Abandon the transfer immediately; no ACK is issued.
  - The bus returns to HTRANS=IDLE in the same cycle as the reset.
  - Requesters must re-issue after reset.

## Test plan
- **Read, no wait:**
  - Stimulus: REQ0, WR0=0, ADDR0=0x80, SIZE0=010; slave returns HRDATA=0xA5A5_0001 with HREADY=1.
  - Response: NONSEQ at N+1; ACK0 at N+3 with RDATA=0xA5A5_0001, ERR=0.
- **Write with 2 wait states in DATA:**
  - Stimulus: REQ1, ADDR1=0x40, WDATA1=0x0000_00FF.
  - Response: HWDATA=0xFF held through the wait cycles; ACK1 at N+5; RDATA unchanged.
- **Simultaneous requests:**
  - Stimulus: REQ0 and REQ1 both high straight out of reset.
  - Response: requester 0 is served first. Requester 1 is then granted in the IDLE cycle after ACK0; its ACK1 follows 4 cycles after ACK0.
- **Slave error:**
  - Stimulus: in DATA, HRESP=1 with HREADY=0 for one cycle, then HRESP=1 with HREADY=1.
  - Response: ACK0 with ERR=1; no retry.
- **Misaligned command:**
  - Stimulus: ADDR0=0x82, SIZE0=010.
  - Response: ACK0 at N+1 with ERR=1; HTRANS stays 00 throughout.
- **Reset during DATA:**
  - Stimulus: assert HRESET during the DATA phase of a write.
  - Response: HTRANS=00, BUSY=0 and no ACK. After reset, a fresh REQ0 completes normally.
